// File: rtl/mips_cpu_harvard_fetch_if.sv
// ---------------------------------------------------------------------------
// mips_cpu_harvard_fetch_if
//
// Purpose: groups the signals between the fetch stage of mips_cpu_harvard
// and its neighbours: the instruction ROM, the decode/execute logic and the
// global run controls.
//
// Signal summary:
//   clk_enable      global advance enable (drives into fetch)
//   stall           hold the PC for multi-cycle execute ops (into fetch)
//   redirect_valid  current instruction is a taken branch/jump (into fetch)
//   redirect_target byte target of the redirect (into fetch)
//   instr_readdata  ROM word, combinational on instr_address (into fetch)
//   instr_address   registered PC (out of fetch)
//   instr_word      instruction to decode, 0 when not active (out of fetch)
//   link_addr       PC+8 for the link instructions (out of fetch)
//   in_delay_slot   current instruction is a delay slot (out of fetch)
//   active          CPU is executing (out of fetch)
//   fetch_err       sticky error flag (out of fetch)
//
// Modports:
//   master  the fetch stage itself
//   slave   the ROM / execute side that talks to the fetch stage
// ---------------------------------------------------------------------------
interface mips_cpu_harvard_fetch_if;
  logic        clk_enable;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instr_readdata;
  logic [31:0] instr_address;
  logic [31:0] instr_word;
  logic [31:0] link_addr;
  logic        in_delay_slot;
  logic        active;
  logic        fetch_err;

  modport master (
    input  clk_enable,
    input  stall,
    input  redirect_valid,
    input  redirect_target,
    input  instr_readdata,
    output instr_address,
    output instr_word,
    output link_addr,
    output in_delay_slot,
    output active,
    output fetch_err
  );

  modport slave (
    output clk_enable,
    output stall,
    output redirect_valid,
    output redirect_target,
    output instr_readdata,
    input  instr_address,
    input  instr_word,
    input  link_addr,
    input  in_delay_slot,
    input  active,
    input  fetch_err
  );
endinterface

// File: rtl/mips_cpu_harvard_fetch.sv
// ---------------------------------------------------------------------------
// mips_cpu_harvard_fetch
//
// Purpose: program counter and instruction fetch for mips_cpu_harvard.
// Drives the instruction ROM address, implements the MIPS branch delay slot
// for branch/jump redirects, and owns the 'active' flag, which drops when
// control reaches HALT_ADDR.
//
// Ports:
//   clk        single clock, all state changes on the rising edge
//   reset      synchronous, active high; overrides clk_enable and stall
//   fetch_bus  mips_cpu_harvard_fetch_if.master (see the interface file)
//
// Parameters:
//   RESET_VECTOR  PC loaded on reset
//   HALT_ADDR     fetch target that ends execution
//
// Build option:
//   FETCH_ADDR_EXC_EN  when defined, a misaligned redirect target sets
//                      fetch_err and halts instead of being loaded; when
//                      undefined, the low two target bits are masked off.
// ---------------------------------------------------------------------------
module mips_cpu_harvard_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic                          clk,
  input  logic                          reset,
  mips_cpu_harvard_fetch_if.master      fetch_bus
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_target;
  logic        r_fetch_err;

  logic [1:0]  w_state_next;
  logic [31:0] w_pc_next;
  logic [31:0] w_target_next;
  logic        w_fetch_err_next;

  logic        w_advance;
  logic [31:0] w_pc_seq;
  logic [31:0] w_load_addr;
  logic        w_load_bad;

  assign w_advance = fetch_bus.clk_enable && !fetch_bus.stall;
  assign w_pc_seq  = r_pc + 32'd4;

  // Address actually loaded when leaving the delay slot, and whether that
  // load is refused as misaligned.
`ifdef FETCH_ADDR_EXC_EN
  assign w_load_addr = r_target;
  assign w_load_bad  = (r_target[1:0] != 2'b00);
`else
  assign w_load_addr = {r_target[31:2], 2'b00};
  assign w_load_bad  = 1'b0;
`endif

  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_target_next    = r_target;
    w_fetch_err_next = r_fetch_err;

    case (r_state)
      ST_RUN: begin
        if (w_pc_seq == HALT_ADDR) begin
          // Sequential flow reaching the halt address wins over a redirect:
          // there is no delay slot to execute once we stop.
          w_pc_next    = HALT_ADDR;
          w_state_next = ST_HALT;
        end else begin
          w_pc_next = w_pc_seq;
          if (fetch_bus.redirect_valid) begin
            w_target_next = fetch_bus.redirect_target;
            w_state_next  = ST_DELAY;
          end
        end
      end

      ST_DELAY: begin
        // A branch sitting in a delay slot is architecturally undefined;
        // keep the first target and flag it.
        if (fetch_bus.redirect_valid) begin
          w_fetch_err_next = 1'b1;
        end
        if (w_load_bad) begin
          w_fetch_err_next = 1'b1;
          w_pc_next        = HALT_ADDR;
          w_state_next     = ST_HALT;
        end else begin
          w_pc_next    = w_load_addr;
          w_state_next = (w_load_addr == HALT_ADDR) ? ST_HALT : ST_RUN;
        end
      end

      ST_HALT: begin
        w_pc_next    = HALT_ADDR;
        w_state_next = ST_HALT;
      end

      default: begin
        w_pc_next    = HALT_ADDR;
        w_state_next = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_pc        <= RESET_VECTOR;
      r_target    <= 32'd0;
      r_fetch_err <= 1'b0;
    end else if (w_advance) begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_target    <= w_target_next;
      r_fetch_err <= w_fetch_err_next;
    end
  end

  assign fetch_bus.instr_address = r_pc;
  assign fetch_bus.active        = (r_state != ST_HALT);
  assign fetch_bus.instr_word    = (r_state != ST_HALT) ? fetch_bus.instr_readdata : 32'd0;
  assign fetch_bus.link_addr     = r_pc + 32'd8;
  assign fetch_bus.in_delay_slot = (r_state == ST_DELAY);
  assign fetch_bus.fetch_err     = r_fetch_err;

endmodule

// File: tb/tb_mips_cpu_harvard_fetch.sv
module tb_mips_cpu_harvard_fetch;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  mips_cpu_harvard_fetch_if bus ();

  mips_cpu_harvard_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .fetch_bus (bus)
  );

  always #5 clk = ~clk;

  // Fake ROM: word is a fixed function of the address.
  assign bus.instr_readdata = bus.instr_address ^ 32'h5A5A0000;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'h5A5A0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_pc(input string tag, input logic [31:0] pc, input logic ds,
                        input logic act, input logic err);
    chk({tag, ".pc"}, bus.instr_address, pc);
    chk({tag, ".ds"}, {31'd0, bus.in_delay_slot}, {31'd0, ds});
    chk({tag, ".act"}, {31'd0, bus.active}, {31'd0, act});
    chk({tag, ".err"}, {31'd0, bus.fetch_err}, {31'd0, err});
    chk({tag, ".word"}, bus.instr_word, act ? rom(pc) : 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset               = 1'b1;
    bus.clk_enable      = 1'b1;
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'd0;

    // Reset and sequential fetch
    do_reset();
    chk_pc("rst", 32'hBFC00000, 1'b0, 1'b1, 1'b0);
    chk("rst.link", bus.link_addr, 32'hBFC00008);
    step(); chk_pc("seq1", 32'hBFC00004, 1'b0, 1'b1, 1'b0);
    step(); chk_pc("seq2", 32'hBFC00008, 1'b0, 1'b1, 1'b0);
    step(); chk_pc("seq3", 32'hBFC0000C, 1'b0, 1'b1, 1'b0);
    chk("seq3.link", bus.link_addr, 32'hBFC00014);

    // Branch with delay slot
    do_reset();
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'hBFC00040;
    step(); chk_pc("br.ds", 32'hBFC00004, 1'b1, 1'b1, 1'b0);
    bus.redirect_valid = 1'b0;
    step(); chk_pc("br.tgt", 32'hBFC00040, 1'b0, 1'b1, 1'b0);

    // Stall in delay slot; a redirect presented while stalled is not sampled
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'hBFC00080;
    step(); chk_pc("st.ds", 32'hBFC00044, 1'b1, 1'b1, 1'b0);
    bus.stall = 1'b1; bus.redirect_target = 32'hBFC00500;
    step(); chk_pc("st.h1", 32'hBFC00044, 1'b1, 1'b1, 1'b0);
    step(); chk_pc("st.h2", 32'hBFC00044, 1'b1, 1'b1, 1'b0);
    step(); chk_pc("st.h3", 32'hBFC00044, 1'b1, 1'b1, 1'b0);
    bus.stall = 1'b0; bus.redirect_valid = 1'b0;
    step(); chk_pc("st.tgt", 32'hBFC00080, 1'b0, 1'b1, 1'b0);
    step(); chk_pc("st.next", 32'hBFC00084, 1'b0, 1'b1, 1'b0);

    // clk_enable low holds everything
    bus.clk_enable = 1'b0;
    step(); chk_pc("ce.hold", 32'hBFC00084, 1'b0, 1'b1, 1'b0);
    bus.clk_enable = 1'b1;

    // Branch in delay slot: first target wins, error flagged and sticky
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'hBFC00100;
    step(); chk_pc("bds.ds", 32'hBFC00088, 1'b1, 1'b1, 1'b0);
    bus.redirect_target = 32'hBFC00200;
    step(); chk_pc("bds.tgt", 32'hBFC00100, 1'b0, 1'b1, 1'b1);
    bus.redirect_valid = 1'b0;
    step(); chk_pc("bds.next", 32'hBFC00104, 1'b0, 1'b1, 1'b1);
    do_reset();
    chk_pc("bds.rst", 32'hBFC00000, 1'b0, 1'b1, 1'b0);

    // Reset in DELAY discards the pending target
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'hBFC00300;
    step(); chk_pc("rd.ds", 32'hBFC00004, 1'b1, 1'b1, 1'b0);
    do_reset();
    chk_pc("rd.rst", 32'hBFC00000, 1'b0, 1'b1, 1'b0);
    step(); chk_pc("rd.next", 32'hBFC00004, 1'b0, 1'b1, 1'b0);

    // Misaligned target
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'hBFC00042;
    step(); chk_pc("mis.ds", 32'hBFC00008, 1'b1, 1'b1, 1'b0);
    bus.redirect_valid = 1'b0;
    step();
`ifdef FETCH_ADDR_EXC_EN
    chk_pc("mis.tgt", 32'h00000000, 1'b0, 1'b0, 1'b1);
`else
    chk_pc("mis.tgt", 32'hBFC00040, 1'b0, 1'b1, 1'b0);
`endif

    // jr $0 halts after the delay slot
    do_reset();
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h00000000;
    step(); chk_pc("jr0.ds", 32'hBFC00004, 1'b1, 1'b1, 1'b0);
    bus.redirect_valid = 1'b0;
    step(); chk_pc("jr0.halt", 32'h00000000, 1'b0, 1'b0, 1'b0);
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'hBFC00040;
    step(); chk_pc("jr0.rv", 32'h00000000, 1'b0, 1'b0, 1'b0);
    bus.clk_enable = 1'b0;
    step(); chk_pc("jr0.ce0", 32'h00000000, 1'b0, 1'b0, 1'b0);
    bus.clk_enable = 1'b1;
    step(); chk_pc("jr0.ce1", 32'h00000000, 1'b0, 1'b0, 1'b0);

    // Sequential wrap past FFFFFFFC reaches address 0 and halts
    do_reset();
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'hFFFFFFF8;
    step(); chk_pc("wr.ds", 32'hBFC00004, 1'b1, 1'b1, 1'b0);
    bus.redirect_valid = 1'b0;
    step(); chk_pc("wr.f8", 32'hFFFFFFF8, 1'b0, 1'b1, 1'b0);
    step(); chk_pc("wr.fc", 32'hFFFFFFFC, 1'b0, 1'b1, 1'b0);
    chk("wr.link", bus.link_addr, 32'h00000004);
    step(); chk_pc("wr.halt", 32'h00000000, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mips_cpu_harvard_fetch.md
# mips_cpu_harvard_fetch

Program-counter and instruction-fetch stage of `mips_cpu_harvard`. It drives the instruction port (`instr_address`), accepts branch/jump redirects from the execute logic, and implements the MIPS branch delay slot. It also owns the `active` flag: execution ends when control transfers to address 0. It consumes `instr_readdata` from the combinational instruction ROM and presents the current instruction word and link address to the decode/execute logic downstream.

## Interface

Parameters:
- `RESET_VECTOR`, default 32'hBFC00000: PC value loaded on reset.
- `HALT_ADDR`, default 32'h00000000: fetch target that terminates execution.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high; overrides `clk_enable` and `stall`.
- `clk_enable` input 1: global advance enable; state holds when low.
- `stall` input 1: hold the PC; asserted by multi-cycle execute ops such as loads and mult/div.
- `redirect_valid` input 1: the instruction at the current PC is a taken branch or jump.
- `redirect_target` input 32: byte target for the redirect.
- `instr_readdata` input 32: instruction word from ROM, combinational on `instr_address`.
- `instr_address` output 32: current PC (registered).
- `instr_word` output 32: current instruction to decode; forced to 0 (nop) when not `active`.
- `link_addr` output 32: PC+8, used by JAL/JALR/BGEZAL/BLTZAL.
- `in_delay_slot` output 1: the current instruction is a delay slot.
- `active` output 1: CPU is executing.
- `fetch_err` output 1: sticky error flag.

## Operation

- States: RUN, DELAY (redirect pending; the current PC is the delay slot), HALT.
- The state, PC, pending target and `fetch_err` update only on an advance cycle (`clk_enable && !stall`), except on reset.
- Reset: PC=`RESET_VECTOR`, state=RUN, `active`=1, `in_delay_slot`=0, `fetch_err`=0, pending target=0.
- RUN, no redirect: PC ← PC+4; stay in RUN.
- RUN with `redirect_valid`: capture `redirect_target`; PC ← PC+4; go to DELAY.
- DELAY: PC ← pending target; go to RUN, or go to HALT if the target equals `HALT_ADDR`.
- DELAY with `redirect_valid` (a branch in a delay slot): the redirect is ignored, the pending target wins, and `fetch_err` is set.
- RUN where the sequential PC+4 equals `HALT_ADDR`: go to HALT.
- HALT: `active`=0; PC holds `HALT_ADDR`; `instr_word`=0; `redirect_valid` is ignored. Only reset leaves HALT.
- PC arithmetic is 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0, which is `HALT_ADDR` by default and therefore halts.
- `link_addr` = `instr_address`+8 (modulo 2^32), combinational.
- `in_delay_slot` = 1 exactly when state=DELAY.

## Timing

- `instr_address` is a register output. `instr_readdata` is valid in the same cycle, and `instr_word` passes it through combinationally.
- Redirect latency: the branch issues at cycle n, the delay slot at n+1, and the target at n+2. There is no bubble.
- `redirect_valid` and `redirect_target` are sampled only on advance cycles. When `stall` is high the redirect must be held until the advancing edge.
- `active` falls on the same edge on which PC becomes `HALT_ADDR`.
- Reset asserted mid-operation, in any state including DELAY with a pending target: on the next edge all outputs return to their reset values and the pending target is discarded.

## Configuration

- `FETCH_ADDR_EXC_EN` defined:
  - a redirect target with `[1:0]`≠0 sets `fetch_err` and sends the block to HALT instead of loading the target;
  - the detection edge is the DELAY→target transition.
- `FETCH_ADDR_EXC_EN` undefined:
  - the low two bits of the target are masked to 0 before loading;
  - misalignment never sets `fetch_err`.

## Test plan

- Reset, then 3 advance cycles with no redirect: `instr_address` = BFC00000, BFC00004, BFC00008, BFC0000C; `active`=1; `link_addr`=BFC00014 in the last cycle.
- Redirect at PC BFC00000 to BFC00040: the next PC is BFC00004 with `in_delay_slot`=1, then BFC00040 with `in_delay_slot`=0.
- Redirect to 0 (the `jr $0` case): delay slot at PC+4; on the next edge `instr_address`=0, `active`=0 and `instr_word`=0. Further redirects and `clk_enable` toggling keep the PC at 0.
- `stall` high for 3 cycles while in DELAY: PC holds its delay-slot value. On release it moves to the target in one cycle, with no lost or duplicated fetch.
- Redirect while in DELAY: `fetch_err`=1 and the original target is fetched. A subsequent reset clears `fetch_err`, sets PC=BFC00000 and sets `active`=1.
- Redirect to BFC00042:
  - with `FETCH_ADDR_EXC_EN`: HALT and `fetch_err`=1;
  - without it: PC becomes BFC00040 and `fetch_err`=0.
